// File: rtl/sobel_row_window.sv
// Three-row sliding window between the memory reader and the Sobel accelerator cores.
// Define SOBEL_ROW_WINDOW_STATS_EN to add the stat_windows consumed-window counter.
module sobel_row_window #(
    parameter int NUM_SOBEL_ACCELERATORS = 4,
    parameter int SOBEL_IDATA_WIDTH      = (NUM_SOBEL_ACCELERATORS + 2) * 8,
    parameter int ROW_CNT_WIDTH          = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ROW_CNT_WIDTH-1:0]     num_rows,
    input  logic [SOBEL_IDATA_WIDTH-1:0] mrd2srow_data,
    input  logic                         mrd2srow_valid,
    output logic                         srow2mrd_ready,
    output logic [SOBEL_IDATA_WIDTH-1:0] srow2sacc_row1_data,
    output logic [SOBEL_IDATA_WIDTH-1:0] srow2sacc_row2_data,
    output logic [SOBEL_IDATA_WIDTH-1:0] srow2sacc_row3_data,
    output logic                         srow2swt_valid,
    input  logic                         swt2srow_ready,
    output logic                         srow2sctl_strip_done
`ifdef SOBEL_ROW_WINDOW_STATS_EN
    ,
    output logic [15:0]                  stat_windows
`endif
);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t                   state;
    logic [ROW_CNT_WIDTH-1:0] rows_in;
    logic [ROW_CNT_WIDTH-1:0] num_rows_q;
    logic                     accept;
    logic                     consume;

    assign accept  = mrd2srow_valid && srow2mrd_ready;
    assign consume = srow2swt_valid && swt2srow_ready;

    // In STREAM a new row may only replace the window once the writer has taken it.
    always_comb begin
        srow2mrd_ready = 1'b0;
        case (state)
            FILL:    srow2mrd_ready = 1'b1;
            STREAM:  srow2mrd_ready = (!srow2swt_valid || swt2srow_ready) && (rows_in < num_rows_q);
            default: srow2mrd_ready = 1'b0;
        endcase
    end

    assign srow2sctl_strip_done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            rows_in             <= '0;
            num_rows_q          <= '0;
            srow2sacc_row1_data <= '0;
            srow2sacc_row2_data <= '0;
            srow2sacc_row3_data <= '0;
            srow2swt_valid      <= 1'b0;
        end else begin
            if (accept) begin
                srow2sacc_row1_data <= srow2sacc_row2_data;
                srow2sacc_row2_data <= srow2sacc_row3_data;
                srow2sacc_row3_data <= mrd2srow_data;
                rows_in             <= rows_in + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        num_rows_q <= num_rows;
                        rows_in    <= '0;
                        state      <= (num_rows >= ROW_CNT_WIDTH'(3)) ? FILL : DONE;
                    end
                end
                FILL: begin
                    if (accept && rows_in == ROW_CNT_WIDTH'(2)) begin
                        srow2swt_valid <= 1'b1;
                        state          <= STREAM;
                    end
                end
                STREAM: begin
                    // Once every row is in, consuming the window means the strip is finished.
                    if (accept) begin
                        srow2swt_valid <= 1'b1;
                    end else if (consume) begin
                        srow2swt_valid <= 1'b0;
                        if (rows_in == num_rows_q) begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SOBEL_ROW_WINDOW_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_windows <= '0;
        end else if (consume) begin
            stat_windows <= stat_windows + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sobel_row_window.sv
// Directed bench for sobel_row_window: per-cycle vector table plus hand-written strip runs.
// Rows are tagged by index n, replicated into every byte of the 48-bit slice.
module tb_sobel_row_window;

    localparam int W = 48;

    logic          clk;
    logic          reset;
    logic          start;
    logic [9:0]    num_rows;
    logic [W-1:0]  mrd2srow_data;
    logic          mrd2srow_valid;
    logic          srow2mrd_ready;
    logic [W-1:0]  srow2sacc_row1_data;
    logic [W-1:0]  srow2sacc_row2_data;
    logic [W-1:0]  srow2sacc_row3_data;
    logic          srow2swt_valid;
    logic          swt2srow_ready;
    logic          srow2sctl_strip_done;
`ifdef SOBEL_ROW_WINDOW_STATS_EN
    logic [15:0]   stat_windows;
`endif

    int checks = 0;
    int errors = 0;

    sobel_row_window #(
        .NUM_SOBEL_ACCELERATORS(4),
        .SOBEL_IDATA_WIDTH(W),
        .ROW_CNT_WIDTH(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .num_rows(num_rows),
        .mrd2srow_data(mrd2srow_data),
        .mrd2srow_valid(mrd2srow_valid),
        .srow2mrd_ready(srow2mrd_ready),
        .srow2sacc_row1_data(srow2sacc_row1_data),
        .srow2sacc_row2_data(srow2sacc_row2_data),
        .srow2sacc_row3_data(srow2sacc_row3_data),
        .srow2swt_valid(srow2swt_valid),
        .swt2srow_ready(swt2srow_ready),
        .srow2sctl_strip_done(srow2sctl_strip_done)
`ifdef SOBEL_ROW_WINDOW_STATS_EN
        ,
        .stat_windows(stat_windows)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit st;
        int nr;
        bit dv;
        int d;
        bit wr;
        bit eRdy;
        bit eVal;
        bit eDone;
        int e1;
        int e2;
        int e3;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [W-1:0] row(input int n);
        logic [7:0] b;
        b = n[7:0];
        return {6{b}};
    endfunction

    function automatic logic [3*W-1:0] win(input int a, input int b, input int c);
        return {row(a), row(b), row(c)};
    endfunction

    task automatic addVec(input bit rst, input bit st, input int nr, input bit dv, input int d,
                          input bit wr, input bit eRdy, input bit eVal, input bit eDone,
                          input int e1, input int e2, input int e3);
        vec_t v;
        v = '{rst, st, nr, dv, d, wr, eRdy, eVal, eDone, e1, e2, e3};
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset          = v.rst;
        start          = v.st;
        num_rows       = 10'(v.nr);
        mrd2srow_valid = v.dv;
        mrd2srow_data  = row(v.d);
        swt2srow_ready = v.wr;
    endtask

    task automatic doReset();
        reset = 1'b1; start = 1'b0; mrd2srow_valid = 1'b0; swt2srow_ready = 1'b0;
        num_rows = '0; mrd2srow_data = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Full strip with an irregular writer; every consumed window must be (k,k+1,k+2).
    task automatic runStrip(input int nr);
        int nextRow = 1;
        int windows = 0;
        int dones = 0;
        bit wasStall;
        logic [3*W-1:0] held;
        start = 1'b1; num_rows = 10'(nr); mrd2srow_valid = 1'b0; swt2srow_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && dones == 0; cyc++) begin
            mrd2srow_valid = 1'b1;
            mrd2srow_data  = row(nextRow);
            swt2srow_ready = (cyc % 3) != 1;
            #1;
            if (srow2swt_valid && swt2srow_ready) begin
                checkOutput("stripWindow",
                            192'({srow2sacc_row1_data, srow2sacc_row2_data, srow2sacc_row3_data}),
                            192'(win(windows + 1, windows + 2, windows + 3)));
                windows++;
            end
            wasStall = srow2swt_valid && !swt2srow_ready;
            held = {srow2sacc_row1_data, srow2sacc_row2_data, srow2sacc_row3_data};
            if (srow2mrd_ready) nextRow++;
            @(posedge clk); #1;
            if (wasStall)
                checkOutput("stallHold",
                            192'({srow2swt_valid, srow2sacc_row1_data, srow2sacc_row2_data, srow2sacc_row3_data}),
                            192'({1'b1, held}));
            if (srow2sctl_strip_done) dones++;
        end
        checkOutput("stripWindowCount", 192'(windows), 192'(nr - 2));
        checkOutput("stripDoneSeen", 192'(dones), 192'(1));
        mrd2srow_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("stripDoneOnce", 192'(srow2sctl_strip_done), 192'(0));
    endtask

    initial begin
        // Scenario 1: num_rows=5, source always valid, writer always ready
        addVec(0,1,5,1,1,1, 0,0,0, 0,0,0);
        addVec(0,0,5,1,1,1, 1,0,0, 0,0,1);
        addVec(0,0,5,1,2,1, 1,0,0, 0,1,2);
        addVec(0,0,5,1,3,1, 1,1,0, 1,2,3);
        addVec(0,0,5,1,4,1, 1,1,0, 2,3,4);
        addVec(0,0,5,1,5,1, 1,1,0, 3,4,5);
        addVec(0,0,5,1,6,1, 0,0,1, 3,4,5);
        addVec(0,0,5,1,6,1, 0,0,0, 3,4,5);
        addVec(0,0,5,1,6,1, 0,0,0, 3,4,5);
        // Scenario 2: num_rows=4, writer stalled 5 cycles on the first window
        addVec(0,1,4,1,1,0, 0,0,0, 3,4,5);
        addVec(0,0,4,1,1,0, 1,0,0, 4,5,1);
        addVec(0,0,4,1,2,0, 1,0,0, 5,1,2);
        addVec(0,0,4,1,3,0, 1,1,0, 1,2,3);
        for (int i = 0; i < 5; i++) addVec(0,0,4,1,4,0, 0,1,0, 1,2,3);
        addVec(0,0,4,1,4,1, 1,1,0, 2,3,4);
        addVec(0,0,4,1,5,1, 0,0,1, 2,3,4);
        addVec(0,0,4,1,5,1, 0,0,0, 2,3,4);
        // Scenario 3: num_rows=2 goes straight to DONE
        addVec(0,1,2,1,1,1, 0,0,1, 2,3,4);
        addVec(0,0,2,1,1,1, 0,0,0, 2,3,4);
        addVec(0,0,2,1,1,1, 0,0,0, 2,3,4);
        // Scenario 4: reset (with a coincident start) after the second window
        addVec(0,1,5,1,1,1, 0,0,0, 2,3,4);
        addVec(0,0,5,1,1,1, 1,0,0, 3,4,1);
        addVec(0,0,5,1,2,1, 1,0,0, 4,1,2);
        addVec(0,0,5,1,3,1, 1,1,0, 1,2,3);
        addVec(0,0,5,1,4,1, 1,1,0, 2,3,4);
        addVec(1,1,3,1,5,1, 1,0,0, 0,0,0);
        addVec(0,0,3,1,1,1, 0,0,0, 0,0,0);
        addVec(0,1,3,1,1,1, 0,0,0, 0,0,0);
        addVec(0,0,3,1,1,1, 1,0,0, 0,0,1);
        addVec(0,0,3,1,2,1, 1,0,0, 0,1,2);
        addVec(0,0,3,1,3,1, 1,1,0, 1,2,3);
        addVec(0,0,3,1,4,1, 0,0,1, 1,2,3);
        addVec(0,0,3,1,4,1, 0,0,0, 1,2,3);
        // Scenario 5: start re-pulsed with a different height during FILL
        addVec(0,1,4,1,1,1, 0,0,0, 1,2,3);
        addVec(0,1,9,1,1,1, 1,0,0, 2,3,1);
        addVec(0,1,9,1,2,1, 1,0,0, 3,1,2);
        addVec(0,0,9,1,3,1, 1,1,0, 1,2,3);
        addVec(0,0,9,1,4,1, 1,1,0, 2,3,4);
        addVec(0,0,9,1,5,1, 0,0,1, 2,3,4);
        addVec(0,0,9,1,5,1, 0,0,0, 2,3,4);

        doReset();
        checkOutput("resetReady", 192'(srow2mrd_ready), 192'(0));
        checkOutput("resetValid", 192'(srow2swt_valid), 192'(0));
        checkOutput("resetDone", 192'(srow2sctl_strip_done), 192'(0));
        checkOutput("resetRows",
                    192'({srow2sacc_row1_data, srow2sacc_row2_data, srow2sacc_row3_data}), 192'(0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d.ready", i), 192'(srow2mrd_ready), 192'(vecs[i].eRdy));
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d.valid", i), 192'(srow2swt_valid), 192'(vecs[i].eVal));
            checkOutput($sformatf("v%0d.done", i), 192'(srow2sctl_strip_done), 192'(vecs[i].eDone));
            checkOutput($sformatf("v%0d.rows", i),
                        192'({srow2sacc_row1_data, srow2sacc_row2_data, srow2sacc_row3_data}),
                        192'(win(vecs[i].e1, vecs[i].e2, vecs[i].e3)));
        end

        reset = 1'b0;
        runStrip(10);

`ifdef SOBEL_ROW_WINDOW_STATS_EN
        doReset();
        checkOutput("statReset", 192'(stat_windows), 192'(0));
        runStrip(10);
        runStrip(10);
        checkOutput("statWindows", 192'(stat_windows), 192'(16));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
